// File: rtl/bitty_alu_pkg.sv
// Shared types and constants for the Bitty ALU: width, opcode enum,
// compare result codes and the bit positions inside the registered flags word.
package bitty_alu_pkg;

  localparam int unsigned WIDTH = 16;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    SHL = 3'd5,
    SHR = 3'd6,
    CMP = 3'd7
  } alu_op_e;

  localparam logic [WIDTH-1:0] CMP_EQ = 16'd0;
  localparam logic [WIDTH-1:0] CMP_GT = 16'd1;
  localparam logic [WIDTH-1:0] CMP_LT = 16'd2;

  // flags word layout is {carry, neg, zero}
  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_NEG   = 1;
  localparam int unsigned FLAG_CARRY = 2;
  localparam int unsigned FLAG_W     = 3;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic carry,
                                                   input logic neg,
                                                   input logic zero);
    logic [FLAG_W-1:0] f;
    f              = 3'b000;
    f[FLAG_CARRY]  = carry;
    f[FLAG_NEG]    = neg;
    f[FLAG_ZERO]   = zero;
    return f;
  endfunction

endpackage

// File: rtl/bitty_alu_core.sv
// Purely combinational Bitty ALU datapath. Flag outputs exist only when
// BITTY_ALU_FLAGS_EN is defined; otherwise the core produces the result alone.
module bitty_alu_core
  import bitty_alu_pkg::*;
(
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       select,
  output logic [WIDTH-1:0] result
`ifdef BITTY_ALU_FLAGS_EN
  ,
  output logic             carry,
  output logic             neg,
  output logic             zero
`endif
);

`ifdef BITTY_ALU_FLAGS_EN
  // one extra bit holds the ADD carry-out / SUB borrow
  localparam int unsigned ARITH_W = WIDTH + 1;
`else
  localparam int unsigned ARITH_W = WIDTH;
`endif

  alu_op_e            op_s;
  logic [ARITH_W-1:0] sum_s;
  logic [ARITH_W-1:0] diff_s;
  logic               shift_big_s;

  assign op_s        = alu_op_e'(select);
  assign sum_s       = ARITH_W'(in_a) + ARITH_W'(in_b);
  assign diff_s      = ARITH_W'(in_a) - ARITH_W'(in_b);
  // any shift amount of WIDTH or more clears the whole word
  assign shift_big_s = (in_b > 16'd15);

  // Opcode decode and result selection.
  always_comb begin
    result = 16'd0;
    case (op_s)
      ADD: result = sum_s[WIDTH-1:0];
      SUB: result = diff_s[WIDTH-1:0];
      AND: result = in_a & in_b;
      OR:  result = in_a | in_b;
      XOR: result = in_a ^ in_b;
      SHL: begin
        if (shift_big_s) result = 16'd0;
        else             result = in_a << in_b[3:0];
      end
      SHR: begin
        if (shift_big_s) result = 16'd0;
        else             result = in_a >> in_b[3:0];
      end
      CMP: begin
        if (in_a == in_b)     result = CMP_EQ;
        else if (in_a > in_b) result = CMP_GT;
        else                  result = CMP_LT;
      end
      default: result = 16'd0;
    endcase
  end

`ifdef BITTY_ALU_FLAGS_EN
  // Carry is the ADD carry-out or the SUB borrow; zero for every other op.
  always_comb begin
    carry = 1'b0;
    case (op_s)
      ADD:     carry = sum_s[ARITH_W-1];
      SUB:     carry = diff_s[ARITH_W-1];
      default: carry = 1'b0;
    endcase
  end

  assign neg  = result[WIDTH-1];
  assign zero = (result == 16'd0);
`endif

endmodule

// File: rtl/bitty_alu.sv
// Bitty ALU top: combinational alu_out plus an en-strobed registered copy of
// result and flags. Optional flag logic is enabled by BITTY_ALU_FLAGS_EN.
module bitty_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       select,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] result_q,
  output logic             valid_q,
  output logic [2:0]       flags_q
);

  import bitty_alu_pkg::*;

  logic [WIDTH-1:0] result_s;
  logic [WIDTH-1:0] result_d;
  logic             valid_d;

`ifdef BITTY_ALU_FLAGS_EN
  logic             carry_s;
  logic             neg_s;
  logic             zero_s;
  logic [FLAG_W-1:0] flags_d;
`endif

  bitty_alu_core u_core (
    .in_a   (in_a),
    .in_b   (in_b),
    .select (select),
    .result (result_s)
`ifdef BITTY_ALU_FLAGS_EN
    ,
    .carry  (carry_s),
    .neg    (neg_s),
    .zero   (zero_s)
`endif
  );

  assign alu_out = result_s;

  // Capture on en; valid is a single-cycle pulse per captured result.
  always_comb begin
    result_d = result_q;
    valid_d  = 1'b0;
    if (en) begin
      result_d = result_s;
      valid_d  = 1'b1;
    end else begin
      result_d = result_q;
      valid_d  = 1'b0;
    end
  end

  // Result and valid registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= 16'd0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

`ifdef BITTY_ALU_FLAGS_EN
  // Flags follow the same capture rule as the result.
  always_comb begin
    flags_d = flags_q;
    if (en) begin
      flags_d = pack_flags(carry_s, neg_s, zero_s);
    end else begin
      flags_d = flags_q;
    end
  end

  // Flag register, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end
`else
  assign flags_q = 3'b000;
`endif

endmodule

// File: tb/tb_bitty_alu.sv
// Directed self-checking bench for bitty_alu: test-plan vectors, a random sweep
// against an independent model, and register/reset behaviour.
module tb_bitty_alu;

  logic        clk;
  logic        reset;
  logic        en;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [2:0]  select;
  logic [15:0] alu_out;
  logic [15:0] result_q;
  logic        valid_q;
  logic [2:0]  flags_q;

  int checks = 0;
  int errors = 0;

  bitty_alu #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .in_a     (in_a),
    .in_b     (in_b),
    .select   (select),
    .alu_out  (alu_out),
    .result_q (result_q),
    .valid_q  (valid_q),
    .flags_q  (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected flags word when the flag feature is compiled in, else zero.
  function automatic logic [2:0] exp_flags(input logic [2:0] f);
`ifdef BITTY_ALU_FLAGS_EN
    return f;
`else
    return 3'b000;
`endif
  endfunction

  // Reference model written with 32-bit arithmetic.
  function automatic logic [15:0] model(input logic [2:0] s, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [31:0] wa;
    logic [31:0] wb;
    logic [31:0] r;
    wa = {16'd0, a};
    wb = {16'd0, b};
    case (s)
      3'd0: r = wa + wb;
      3'd1: r = wa + (32'h0001_0000 - wb);
      3'd2: r = wa & wb;
      3'd3: r = wa | wb;
      3'd4: r = wa ^ wb;
      3'd5: r = (wb < 32'd16) ? (wa << wb) : 32'd0;
      3'd6: r = (wb < 32'd16) ? (wa >> wb) : 32'd0;
      default: r = (wa == wb) ? 32'd0 : ((wa > wb) ? 32'd1 : 32'd2);
    endcase
    return r[15:0];
  endfunction

  task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s);
    in_a   = a;
    in_b   = b;
    select = s;
    #1;
  endtask

  task automatic capture();
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [2:0]  rs;

    reset  = 1'b1;
    en     = 1'b0;
    in_a   = 16'd0;
    in_b   = 16'd0;
    select = 3'd0;
    #2;
    chk("reset_result", result_q, 16'h0000);
    chk("reset_valid", {15'd0, valid_q}, 16'h0000);
    chk("reset_flags", {13'd0, flags_q}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // ADD wrap, then capture
    apply(16'hFFFF, 16'h0001, 3'd0);
    chk("add_wrap", alu_out, 16'h0000);
    capture();
    chk("add_wrap_result_q", result_q, 16'h0000);
    chk("add_wrap_valid", {15'd0, valid_q}, 16'h0001);
    chk("add_wrap_flags", {13'd0, flags_q}, {13'd0, exp_flags(3'b101)});

    // SUB borrow: valid must drop after one cycle while result_q holds
    apply(16'h0003, 16'h0005, 3'd1);
    chk("sub_borrow", alu_out, 16'hFFFE);
    capture();
    chk("sub_result_q", result_q, 16'hFFFE);
    chk("sub_flags", {13'd0, flags_q}, {13'd0, exp_flags(3'b110)});
    @(posedge clk);
    #1;
    chk("valid_one_cycle", {15'd0, valid_q}, 16'h0000);
    chk("result_hold", result_q, 16'hFFFE);

    apply(16'h0F0F, 16'h00FF, 3'd2);
    chk("and", alu_out, 16'h000F);
    apply(16'h0F0F, 16'h00FF, 3'd3);
    chk("or", alu_out, 16'h0FFF);
    apply(16'h0F0F, 16'h00FF, 3'd4);
    chk("xor", alu_out, 16'h0FF0);

    apply(16'h0001, 16'd4, 3'd5);
    chk("shl4", alu_out, 16'h0010);
    apply(16'h8000, 16'd15, 3'd6);
    chk("shr15", alu_out, 16'h0001);
    apply(16'h1234, 16'd16, 3'd5);
    chk("shl16", alu_out, 16'h0000);
    apply(16'h1234, 16'h0100, 3'd6);
    chk("shr256", alu_out, 16'h0000);

    apply(16'h00AA, 16'h00AA, 3'd7);
    chk("cmp_eq", alu_out, 16'd0);
    apply(16'h0100, 16'h00FF, 3'd7);
    chk("cmp_gt", alu_out, 16'd1);
    apply(16'h0001, 16'h0002, 3'd7);
    chk("cmp_lt", alu_out, 16'd2);
    capture();
    chk("cmp_lt_flags", {13'd0, flags_q}, {13'd0, exp_flags(3'b000)});

    apply(16'd10, 16'h00C8, 3'd0);
    chk("imm_add", alu_out, 16'd210);

    // back-to-back captures keep valid high and update result each edge
    apply(16'h0001, 16'd4, 3'd5);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_1_result", result_q, 16'h0010);
    chk("b2b_1_valid", {15'd0, valid_q}, 16'h0001);
    in_a = 16'h8000;
    in_b = 16'h8000;
    select = 3'd0;
    @(posedge clk);
    #1;
    en = 1'b0;
    chk("b2b_2_result", result_q, 16'h0000);
    chk("b2b_2_valid", {15'd0, valid_q}, 16'h0001);
    chk("b2b_2_flags", {13'd0, flags_q}, {13'd0, exp_flags(3'b101)});

    // mid-cycle reset with en high clears registers before any edge
    apply(16'h8000, 16'h0001, 3'd3);
    capture();
    chk("pre_reset_result", result_q, 16'h8001);
    en = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_result", result_q, 16'h0000);
    chk("midrst_valid", {15'd0, valid_q}, 16'h0000);
    chk("midrst_flags", {13'd0, flags_q}, 16'h0000);
    en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_idle_valid", {15'd0, valid_q}, 16'h0000);
    chk("post_reset_idle_result", result_q, 16'h0000);

    // random sweep over all selects; every third vector uses a small b for shifts
    for (int i = 0; i < 48; i++) begin
      ra = 16'($urandom);
      rb = (i % 3 == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      rs = 3'(i % 8);
      apply(ra, rb, rs);
      chk($sformatf("sweep sel=%0d a=%h b=%h", rs, ra, rb), alu_out, model(rs, ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitty_alu.md
# bitty_alu

16-bit arithmetic/logic unit of the Bitty processor datapath. It computes one of eight operations on two 16-bit operands, selected by a 3-bit opcode field taken from the instruction. The combinational result feeds the control unit's result register. An optional registered copy of the result and status flags is provided for pipelined or bench use.

## Interface
Parameters:
- WIDTH, 16, operand/result width; only 16 is supported.

Ports:
- Reset is `reset`: asynchronous, active-high. The clock is `clk`.
- clk  in  1  rising-edge clock; used only for the registered outputs.
- reset  in  1  asynchronous, active-high; clears all registered outputs.
- en  in  1  capture strobe for the registered result.
- in_a  in  16  operand A; the Rx register value.
- in_b  in  16  operand B; the Ry register value, or a zero-extended 8-bit immediate.
- select  in  3  operation code.
- alu_out  out  16  combinational result.
- result_q  out  16  registered result.
- valid_q  out  1  high for one cycle after each captured result.
- flags_q  out  3  registered flags {carry, neg, zero}.

## Operation
select encoding; all arithmetic is modulo 2^16 and unsigned unless noted:
- 0 ADD: a + b. carry = bit 16 of the 17-bit sum.
- 1 SUB: a - b. carry = borrow, i.e. 1 when a < b unsigned.
- 2 AND: a & b.
- 3 OR: a | b.
- 4 XOR: a ^ b.
- 5 SHL: a << b.
  - Shift amount is the full unsigned value of b.
  - b ≥ 16 gives 0.
- 6 SHR: a >> b, logical.
  - Shift amount is the full unsigned value of b.
  - b ≥ 16 gives 0.
- 7 CMP, unsigned comparison:
  - a == b gives 0.
  - a > b gives 1.
  - a < b gives 2.

Common rules:
- For all operations other than ADD and SUB, carry = 0.
- zero = (result == 0). neg = result[15].
- alu_out is purely combinational from in_a, in_b and select. It is independent of clk, reset and en.

## Timing
- alu_out has zero-cycle latency and settles within the same cycle as its inputs.
- On a rising clk edge with en = 1:
  - result_q ← alu_out.
  - flags_q ← the flags computed from the current inputs.
  - valid_q ← 1.
- On a rising clk edge with en = 0: result_q and flags_q hold; valid_q ← 0.
- Reset asserted, at any time:
  - result_q = 0, flags_q = 0, valid_q = 0 immediately, with no clock needed.
  - A capture in progress is discarded.
- Reset deasserted: the first capture happens on the first rising edge with en = 1.
- Back-to-back en keeps valid_q high continuously; each cycle captures a new result.

## Configuration
- BITTY_ALU_FLAGS_EN defined:
  - The flag logic and the flags_q register are compiled in.
  - CMP and the carry computation are as specified above.
- BITTY_ALU_FLAGS_EN undefined:
  - flags_q is tied to 3'b000 and no flag logic is synthesized.
  - alu_out, result_q and valid_q behaviour is unchanged.

## Structure
- Package bitty_alu_pkg holds:
  - The WIDTH constant (16).
  - The enum alu_op_e: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, CMP=7.
  - The CMP result constants: CMP_EQ=0, CMP_GT=1, CMP_LT=2.
  - Flag bit-index constants.
- Sub-module bitty_alu_core is purely combinational and produces the result, carry, neg and zero.
- The top module bitty_alu wraps bitty_alu_core and adds the en/valid/flag registers and reset logic.

## Test plan
- ADD/SUB wrap:
  - a=0xFFFF, b=0x0001, sel=0 → alu_out=0x0000, after en: flags_q={1,0,1}.
  - a=0x0003, b=0x0005, sel=1 → alu_out=0xFFFE, carry=1, neg=1.
- Logic ops with a=0x0F0F, b=0x00FF:
  - sel=2 → 0x000F.
  - sel=3 → 0x0FFF.
  - sel=4 → 0x0FF0.
- Shifts:
  - a=0x0001, b=4, sel=5 → 0x0010.
  - a=0x8000, b=15, sel=6 → 0x0001.
  - a=0x1234, b=16, sel=5 → 0x0000.
- Compare:
  - a=b=0x00AA, sel=7 → 0.
  - a=0x0100, b=0x00FF → 1.
  - a=0x0001, b=0x0002 → 2.
- Immediate path: a=10, b=0x00C8 (zero-extended 200), sel=0 → 210. Also a random sweep of all selects against a software model, with zero mismatches.
- Register/reset behaviour:
  - en pulse → valid_q high for exactly one cycle and result_q matches alu_out.
  - Assert reset mid-cycle → result_q, flags_q and valid_q are 0 before the next edge.
